// File: rtl/matrix_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package : matrix_feeder_pkg
// Brief   : FSM encoding and buffer sizing helpers for matrix_feeder
// Rev     : 1.0 - initial release
// ============================================================================
package matrix_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_STREAM = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  // One operand set is A (rows x cols) followed by B (cols x rows).
  function automatic int total_words(input int rows, input int cols);
    return 2 * rows * cols;
  endfunction

  function automatic int cnt_width(input int rows, input int cols);
    return $clog2(total_words(rows, cols) + 1);
  endfunction

  function automatic int addr_width(input int rows, input int cols);
    return (total_words(rows, cols) <= 1) ? 1 : $clog2(total_words(rows, cols));
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_feeder_buf.sv
`default_nettype none
// ============================================================================
// Module : matrix_feeder_buf
// Brief  : Single-port operand RAM, synchronous write, registered read
// Rev    : 1.0 - initial release
// ============================================================================
module matrix_feeder_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  // Output register returns to zero whenever no read is issued, so it can
  // drive the multiplier directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  r_rdata <= '0;
    else if (re) r_rdata <= r_mem[addr];
    else         r_rdata <= '0;
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module : matrix_feeder
// Brief  : Buffers one A/B operand set from the host and replays it to the
//          matrix multiplier after a start pulse
// Rev    : 1.0 - initial release
// ============================================================================
module matrix_feeder
  import matrix_feeder_pkg::*;
#(
  parameter int DW = 8,
  parameter int M  = 8,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] mm_data,
  output logic          mm_start,
  input  logic          mm_done,
  output logic          busy,
  output logic          batch_done
);

  localparam int c_TOTAL = total_words(M, N);
  localparam int c_CW    = cnt_width(M, N);
  localparam int c_AW    = addr_width(M, N);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_TOTAL - 1);
  localparam logic [c_CW-1:0] c_END  = c_CW'(c_TOTAL);

  state_t          r_state;
  state_t          w_next;
  logic [c_CW-1:0] r_wr_cnt;
  logic [c_CW-1:0] r_rd_cnt;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_batch_done;
  logic            w_hs;
  logic            w_we;
  logic            w_re;
  logic [c_AW-1:0] w_addr;

  assign w_hs = in_valid & r_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_re   = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_hs) begin
          w_we   = 1'b1;
          w_next = (r_wr_cnt == c_LAST) ? ST_START : ST_LOAD;
        end
      end
      ST_START: begin
        w_re   = 1'b1;
        w_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (r_rd_cnt != c_END) w_re   = 1'b1;
        else                   w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Write and read phases never overlap, so one address port is shared.
  assign w_addr = ((r_state == ST_START) || (r_state == ST_STREAM)) ?
                  r_rd_cnt[c_AW-1:0] : r_wr_cnt[c_AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_in_ready   <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
      r_batch_done <= (r_state == ST_WAIT) && mm_done;

      if ((r_state == ST_IDLE) && w_hs)         r_busy <= 1'b1;
      else if ((r_state == ST_WAIT) && mm_done) r_busy <= 1'b0;

      if (w_we)                      r_wr_cnt <= r_wr_cnt + c_CW'(1);
      else if (r_state == ST_START)  r_wr_cnt <= '0;

      // Loading restarts the read pointer so START always reads word 0.
      if (w_re)      r_rd_cnt <= r_rd_cnt + c_CW'(1);
      else if (w_we) r_rd_cnt <= '0;
    end
  end

  matrix_feeder_buf #(
    .DW    (DW),
    .DEPTH (c_TOTAL),
    .AW    (c_AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_addr),
    .wdata (in_data),
    .rdata (mm_data)
  );

  assign in_ready   = r_in_ready;
  assign mm_start   = (r_state == ST_START);
  assign busy       = r_busy;
  assign batch_done = r_batch_done;

endmodule
`default_nettype wire
